// File: rtl/mult_seq_unit_if.sv
// Handshake/result bundle between the EX-stage issue logic and the sequential multiplier.
// The master drives the request side; the multiplier (slave) drives the HiLo-facing results.
interface mult_seq_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic                 start;
    logic                 is_signed;
    logic                 acc_in;
    logic [WIDTH-1:0]     OpA;
    logic [WIDTH-1:0]     OpB;
    logic [2*WIDTH-1:0]   MultAns;
    logic [CNT_W-1:0]     Signal;
    logic                 add;
    logic                 busy;

    modport master (
        output start, is_signed, acc_in, OpA, OpB,
        input  MultAns, Signal, add, busy
    );

    modport slave (
        input  start, is_signed, acc_in, OpA, OpB,
        output MultAns, Signal, add, busy
    );
endinterface

// File: rtl/mult_seq_unit.sv
// Radix-2 shift-add multiplier for MULT/MULTU/MADD/MADDU feeding the HiLo register.
// One product per start; Signal counts the iterations, then pulses OUT_CODE for one cycle.
module mult_seq_unit #(
    parameter int               WIDTH    = 32,
    parameter int               CNT_W    = 6,
    parameter logic [CNT_W-1:0] OUT_CODE = 6'b111111
) (
    input  logic            clk,
    input  logic            reset,
    mult_seq_unit_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

    logic [1:0]        state;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [CNT_W-1:0]  count;
    logic              neg;
    logic              acc_lat;

    logic              take;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              neg_next;

    // Signed operands are reduced to magnitudes; -2^31 keeps its bit pattern as unsigned 2^31.
    always_comb begin
        take     = bus.start && (state == S_IDLE || state == S_DONE);
        a_mag    = (bus.is_signed && bus.OpA[WIDTH-1]) ? -bus.OpA : bus.OpA;
        b_mag    = (bus.is_signed && bus.OpB[WIDTH-1]) ? -bus.OpB : bus.OpB;
        neg_next = bus.is_signed && (bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            count       <= '0;
            neg         <= 1'b0;
            acc_lat     <= 1'b0;
            bus.MultAns <= '0;
            bus.Signal  <= '0;
            bus.add     <= 1'b0;
            bus.busy    <= 1'b0;
        end else if (take) begin
            state       <= S_RUN;
            acc         <= '0;
            mcand       <= {{WIDTH{1'b0}}, a_mag};
            mplier      <= b_mag;
            count       <= '0;
            neg         <= neg_next;
            acc_lat     <= bus.acc_in;
            bus.Signal  <= ONE;
            bus.busy    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.Signal <= '0;
                    bus.busy   <= 1'b0;
                end
                S_RUN: begin
                    // The finishing cycle after the last step only applies the sign, so the
                    // final product comes straight from a register rather than an adder chain.
                    if (count == LAST) begin
                        state       <= S_DONE;
                        bus.MultAns <= neg ? -acc : acc;
                        bus.Signal  <= OUT_CODE;
                        bus.add     <= acc_lat;
                        bus.busy    <= 1'b0;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + ONE;
                        if (count < LAST - ONE) begin
                            bus.Signal <= count + TWO;
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    bus.Signal <= '0;
                    bus.busy   <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    bus.Signal <= '0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit: directed corner cases plus randomized operands
// checked against a plain-arithmetic product model.
module tb_mult_seq_unit;
    localparam int         WIDTH    = 32;
    localparam int         CNT_W    = 6;
    localparam logic [5:0] OUT_CODE = 6'b111111;
    localparam int         LAT      = 33;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mult_seq_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mult_seq_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W), .OUT_CODE(OUT_CODE)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic acc);
        bus.OpA       = a;
        bus.OpB       = b;
        bus.is_signed = s;
        bus.acc_in    = acc;
        bus.start     = 1'b1;
    endtask

    // Issues one start and returns the product seen with OUT_CODE; lat = -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic acc, output logic [63:0] prod, output logic add_o,
                          output int lat);
        @(negedge clk);
        drive(a, b, s, acc);
        @(negedge clk);
        bus.start = 1'b0;
        lat   = -1;
        prod  = '0;
        add_o = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.Signal == OUT_CODE) begin
                lat   = k;
                prod  = bus.MultAns;
                add_o = bus.add;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.acc_in    = 1'b0;
        bus.OpA       = '0;
        bus.OpB       = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.MultAns !== 64'h0) begin
            n_fail++; $display("FAIL reset_multans got=%h exp=0", bus.MultAns);
        end
        n_tests++;
        if (bus.Signal !== 6'h0) begin
            n_fail++; $display("FAIL reset_signal got=%h exp=0", bus.Signal);
        end
        n_tests++;
        if (bus.add !== 1'b0) begin
            n_fail++; $display("FAIL reset_add got=%b exp=0", bus.add);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int bad_sig  = 0;
        int bad_busy = 0;
        @(negedge clk);
        drive(32'd3, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= 31 && bus.Signal !== 6'(k + 1)) begin
                bad_sig++;
                $display("FAIL lat_count k=%0d got=%0d exp=%0d", k, bus.Signal, k + 1);
            end
            if (k == 32 && bus.Signal === OUT_CODE) begin
                bad_sig++; $display("FAIL lat_early_done k=32 got=%h", bus.Signal);
            end
            if (bus.busy !== 1'b1) begin
                bad_busy++; $display("FAIL lat_busy k=%0d got=%b exp=1", k, bus.busy);
            end
        end
        n_tests++;
        if (bad_sig != 0) n_fail++;
        n_tests++;
        if (bad_busy != 0) n_fail++;
        @(negedge clk);
        n_tests++;
        if (bus.Signal !== OUT_CODE) begin
            n_fail++; $display("FAIL lat_done_code got=%h exp=%h", bus.Signal, OUT_CODE);
        end
        n_tests++;
        if (bus.MultAns !== 64'hF) begin
            n_fail++; $display("FAIL lat_product got=%h exp=f", bus.MultAns);
        end
        n_tests++;
        if (bus.add !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL lat_done_flags add=%b busy=%b exp=0,0", bus.add, bus.busy);
        end
        @(negedge clk);
        n_tests++;
        if (bus.Signal !== 6'h0 || bus.MultAns !== 64'hF) begin
            n_fail++;
            $display("FAIL lat_after_done sig=%h ans=%h exp=0,f", bus.Signal, bus.MultAns);
        end
    endtask

    task automatic test_corners();
        logic [31:0] ta [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        logic [31:0] tb [5] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF0};
        logic        ts [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] te [5] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFE_0000_0001, 64'h1,
                                64'h4000_0000_0000_0000, 64'h0};
        logic [63:0] prod;
        logic        add_o;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], ts[i], 1'b0, prod, add_o, lat);
            n_tests++;
            if (lat != LAT || prod !== te[i]) begin
                n_fail++;
                $display("FAIL corner_%0d got=%h lat=%0d exp=%h lat=%0d", i, prod, lat, te[i], LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        acc;
        logic [63:0] prod;
        logic        add_o;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            a   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            s   = 1'($urandom_range(0, 1));
            acc = 1'($urandom_range(0, 1));
            run_op(a, b, s, acc, prod, add_o, lat);
            n_tests++;
            if (lat != LAT || prod !== ref_mul(a, b, s) || add_o !== acc) begin
                n_fail++;
                $display("FAIL random_%0d a=%h b=%h s=%b got=%h add=%b lat=%0d exp=%h add=%b lat=%0d",
                         i, a, b, s, prod, add_o, lat, ref_mul(a, b, s), acc, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1    = $urandom;
        logic [31:0] b1    = $urandom | 32'h1;
        int          pulses = 0;
        int          first  = -1;
        logic [63:0] prod1  = '0;
        logic        add1   = 1'b1;
        int          second = -1;
        logic [63:0] prod2  = '0;
        logic        add2   = 1'b0;
        @(negedge clk);
        drive(a1, b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 4) drive(32'h1234_5678, 32'h0000_0F0F, 1'b1, 1'b1);
            if (k == 5) bus.start = 1'b0;
            if (bus.Signal == OUT_CODE) begin
                pulses++;
                if (first < 0) begin
                    first = k; prod1 = bus.MultAns; add1 = bus.add;
                end
            end
        end
        drive(32'd7, 32'd6, 1'b0, 1'b1);
        n_tests++;
        if (pulses != 1 || first != LAT) begin
            n_fail++; $display("FAIL busy_ignore pulses=%0d at=%0d exp=1 at=%0d", pulses, first, LAT);
        end
        n_tests++;
        if (prod1 !== ref_mul(a1, b1, 1'b0) || add1 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_first_result got=%h add=%b exp=%h add=0", prod1, add1, ref_mul(a1, b1, 1'b0));
        end
        @(negedge clk);
        bus.start = 1'b0;
        n_tests++;
        if (bus.Signal !== 6'd1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL done_restart sig=%h busy=%b exp=1,1", bus.Signal, bus.busy);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.Signal == OUT_CODE && second < 0) begin
                second = k; prod2 = bus.MultAns; add2 = bus.add;
            end
        end
        n_tests++;
        if (second != LAT || prod2 !== 64'd42 || add2 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_second got=%h add=%b at=%0d exp=2a add=1 at=%0d", prod2, add2, second, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int          found  = 0;
        int          pulses = 0;
        logic [63:0] prod;
        logic        add_o;
        int          lat;
        @(negedge clk);
        drive(32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.Signal == 6'd11) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (found == 0) begin
            n_fail++; $display("FAIL rstmid_reach got=%0d exp=11", bus.Signal);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.MultAns !== 64'h0 || bus.Signal !== 6'h0 || bus.add !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear ans=%h sig=%h add=%b busy=%b exp=0", bus.MultAns, bus.Signal,
                     bus.add, bus.busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.Signal == OUT_CODE) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL rstmid_no_done pulses=%0d exp=0", pulses);
        end
        run_op(32'd2, 32'd2, 1'b0, 1'b0, prod, add_o, lat);
        n_tests++;
        if (lat != LAT || prod !== 64'd4) begin
            n_fail++; $display("FAIL rstmid_restart got=%h lat=%0d exp=4 lat=%0d", prod, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_seq_unit.md
Name: mult_seq_unit

Overview:
- Multi-cycle radix-2 shift-add multiplier for MULT/MULTU/MADD/MADDU.
- Sits in the EX stage directly upstream of the HiLo register.
- Drives the HiLo inputs MultAns, Signal and add.
- Produces one 64-bit product per start after a fixed latency, then flags completion with the 6'b111111 code that HiLo samples.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 6, width of the Signal/iteration code.
- OUT_CODE, 6'b111111, Signal value marking a valid product (the HiLo capture code).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled on clk rising edge.
- is_signed  in  1  1 = two's-complement operands (MULT/MADD); 0 = unsigned.
- acc_in  in  1  1 = accumulate into HiLo (MADD/MADDU); latched with operands.
- OpA  in  WIDTH  multiplicand (rs).
- OpB  in  WIDTH  multiplier (rt).
- MultAns  out  2*WIDTH  product, registered.
- Signal  out  CNT_W  status code, registered.
- add  out  1  latched acc_in, registered.
- busy  out  1  1 while iterating; start ignored.

Behaviour:
- Reset (reset=0, async): state=IDLE; MultAns=0, Signal=0, add=0, busy=0; internal accumulator, operand and count registers cleared.
- Reset mid-operation aborts immediately; no OUT_CODE is produced; the next start after release begins fresh.
- States: IDLE, RUN, DONE.
- IDLE:
  - Signal=0, busy=0.
  - start=1 at an edge latches the operands, is_signed and acc_in, then goes to RUN with count=0.
  - For a signed operation, latch |OpA| and |OpB|, and neg = OpA[31]^OpB[31].
  - For an unsigned operation, latch the raw operands and neg=0.
- RUN:
  - busy=1; Signal = count+1 (1..32).
  - Each edge: if multiplier LSB=1, add the multiplicand (zero-extended, shifted by count) into the 64-bit accumulator; shift the multiplier right; count++.
  - After the 32nd step edge, go to DONE.
  - start is ignored throughout RUN.
- DONE (exactly one cycle):
  - MultAns = neg ? two's-complement negate of the accumulator : accumulator.
  - Signal = OUT_CODE; add = latched acc_in; busy=0.
  - start=1 in DONE is accepted as in IDLE and goes to RUN; Signal still returns to a RUN code, so OUT_CODE never lasts longer than one cycle.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0 → Signal=OUT_CODE and MultAns valid during the cycle after edge E33; Signal=0 after E34.
- Throughput: one result per 33 cycles with back-to-back starts.
- MultAns holds its last value in IDLE and RUN; it updates only on entry to DONE.
- add holds its value until the next DONE.
- Arithmetic:
  - Full 64-bit accumulator, no truncation.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 2^31, so the signed (-2^31)·(-2^31) case is correct.
  - Zero operands produce 0 with neg ignored; negating 0 yields 0.
- Outputs depend only on registers; no combinational path from inputs to outputs.

Test Plan:
- Unsigned 3×5, acc_in=0, start pulse at E0 → Signal counts 1..32, then Signal=6'b111111 for one cycle after E33 with MultAns=64'h0000_0000_0000_000F, add=0; Signal=0 after E34.
- Signed OpA=32'hFFFF_FFFE (-2) × OpB=3 → MultAns=64'hFFFF_FFFF_FFFF_FFFA.
- Unsigned 32'hFFFF_FFFF × 32'hFFFF_FFFF → 64'hFFFF_FFFE_0000_0001.
  - Same operands signed → 64'h0000_0000_0000_0001.
  - Signed 32'h8000_0000 × 32'h8000_0000 → 64'h4000_0000_0000_0000.
- Second start at E5 with different operands while busy → ignored; the first result is unchanged and exactly one OUT_CODE pulse occurs.
  - Then start asserted during the DONE cycle with acc_in=1, 7×6 → accepted; the next OUT_CODE shows MultAns=42, add=1.
- Assert reset low asynchronously at mid-RUN (count=10) → MultAns, Signal, add and busy read 0 before the next edge; no OUT_CODE.
  - After release, a 2×2 start yields MultAns=4 at the normal latency.
